// File: rtl/instr_fetch_queue_if.sv
// Fetch-queue bus: instruction-memory read port, issue-side dequeue handshake and redirect.
interface instr_fetch_queue_if #(
  parameter int IW = 16,
  parameter int AW = 4
);
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_data;
  logic          deq_ready;
  logic          deq_valid;
  logic [IW-1:0] deq_instr;
  logic [AW-1:0] deq_pc;
  logic          flush;
  logic [AW-1:0] flush_pc;

  modport master (
    output imem_addr, deq_valid, deq_instr, deq_pc,
    input  imem_data, deq_ready, flush, flush_pc
  );

  modport slave (
    input  imem_addr, deq_valid, deq_instr, deq_pc,
    output imem_data, deq_ready, flush, flush_pc
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// Fetch stage: reads one word per cycle at pc into a circular queue drained in order by issue;
// stops at a halt opcode or the last memory word and restarts on flush.
module instr_fetch_queue #(
  parameter int          QDEPTH  = 4,
  parameter int          IW      = 16,
  parameter int          AW      = 4,
  parameter logic [3:0]  HALT_OP = 4'hF
) (
  input  logic                        clk,
  input  logic                        rst,
  instr_fetch_queue_if.master         bus,
  output logic [$clog2(QDEPTH):0]     iq_count,
  output logic                        iq_full,
  output logic                        iq_empty,
  output logic                        fetch_halted
);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {FETCH, HALTED} state_t;

  state_t        state, state_next;
  logic [IW-1:0] instr  [QDEPTH];
  logic [AW-1:0] pc_tag [QDEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic [AW-1:0] pc;
  logic          enq, deq, halt_hit;

  assign iq_count     = count;
  assign iq_full      = (count == CW'(QDEPTH));
  assign iq_empty     = (count == '0);
  assign fetch_halted = (state == HALTED);

  assign bus.imem_addr = pc;
  assign bus.deq_valid = !bus.flush && !iq_empty;
  assign bus.deq_instr = instr[head];
  assign bus.deq_pc    = pc_tag[head];

  // Flush suppresses both sides of the queue so the redirect cycle is a clean restart.
  assign deq      = bus.deq_valid && bus.deq_ready;
  assign enq      = (state == FETCH) && (!iq_full || deq) && !bus.flush;
  assign halt_hit = (bus.imem_data[IW-1 -: 4] == HALT_OP) || (pc == '1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      FETCH:  if (bus.flush) state_next = FETCH;
              else if (enq && halt_hit) state_next = HALTED;
      HALTED: if (bus.flush) state_next = FETCH;
      default: state_next = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      pc    <= '0;
      for (int unsigned i = 0; i < QDEPTH; i++) begin
        instr[i]  <= '0;
        pc_tag[i] <= '0;
      end
    end else if (bus.flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      pc    <= bus.flush_pc;
    end else begin
      if (enq) begin
        instr[tail]  <= bus.imem_data;
        pc_tag[tail] <= pc;
        tail         <= tail + 1'b1;
        if (!halt_hit) pc <= pc + 1'b1;
      end
      if (deq) head <= head + 1'b1;
      unique case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomised bench for instr_fetch_queue: a queue-based reference model predicts every fetched
// word; a negedge monitor pops predictions whenever the DUT hands an instruction to issue.
module tb_instr_fetch_queue;
  localparam int QDEPTH = 4;
  localparam int IW     = 16;
  localparam int AW     = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] iq_count;
  logic       iq_full, iq_empty, fetch_halted;

  instr_fetch_queue_if #(.IW(IW), .AW(AW)) bus ();

  instr_fetch_queue #(.QDEPTH(QDEPTH), .IW(IW), .AW(AW), .HALT_OP(4'hF)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .iq_count(iq_count), .iq_full(iq_full), .iq_empty(iq_empty), .fetch_halted(fetch_halted)
  );

  always #5 clk = ~clk;

  logic [15:0] imem [16];
  assign bus.imem_data = imem[bus.imem_addr];

  typedef struct packed { logic [15:0] w; logic [3:0] pc; } ent_t;

  ent_t       exp_q[$];
  logic [3:0] mpc;
  bit         mhalt;
  int         vectors = 0;
  int         miscompares = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endfunction

  // Monitor: compares observable state against the model and retires delivered instructions.
  bit   ev;
  ent_t e;
  always @(negedge clk) begin
    #1;
    if (!rst) begin
      ev = !bus.flush && (exp_q.size() != 0);
      check("deq_valid", bus.deq_valid, ev);
      check("iq_count", iq_count, exp_q.size());
      check("iq_full", iq_full, exp_q.size() == QDEPTH);
      check("iq_empty", iq_empty, exp_q.size() == 0);
      check("imem_addr", bus.imem_addr, mpc);
      check("fetch_halted", fetch_halted, mhalt);
      if (ev && bus.deq_ready) begin
        e = exp_q.pop_front();
        check("deq_instr", bus.deq_instr, e.w);
        check("deq_pc", bus.deq_pc, e.pc);
      end
    end
  end

  // One cycle of stimulus; the model advances after the monitor has retired this cycle's pop.
  task automatic step(input bit rdy, input bit fl, input logic [3:0] fpc);
    @(negedge clk);
    rst          = 1'b0;
    bus.deq_ready = rdy;
    bus.flush    = fl;
    bus.flush_pc = fpc;
    #2;
    if (fl) begin
      exp_q.delete();
      mpc   = fpc;
      mhalt = 1'b0;
    end else if (!mhalt && exp_q.size() < QDEPTH) begin
      exp_q.push_back({imem[mpc], mpc});
      if (imem[mpc][15:12] == 4'hF || mpc == 4'hF) mhalt = 1'b1;
      else mpc = mpc + 4'd1;
    end
  endtask

  task automatic fill_imem();
    for (int i = 0; i < 16; i++)
      imem[i] = {($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom_range(0, 14)), 12'($urandom)};
  endtask

  initial begin
    for (int i = 0; i < 16; i++) imem[i] = {4'($urandom_range(0, 14)), 12'($urandom)};
    imem[0] = 16'h1123; imem[1] = 16'h2456; imem[2] = 16'h3789; imem[3] = 16'h0ABC;
    rst = 1'b1; bus.deq_ready = 1'b0; bus.flush = 1'b0; bus.flush_pc = '0;
    exp_q.delete(); mpc = '0; mhalt = 1'b0;
    #1;
    check("rst iq_count", iq_count, 0);
    check("rst iq_empty", iq_empty, 1);
    check("rst iq_full", iq_full, 0);
    check("rst fetch_halted", fetch_halted, 0);
    check("rst deq_valid", bus.deq_valid, 0);
    check("rst deq_instr", bus.deq_instr, 0);
    check("rst deq_pc", bus.deq_pc, 0);
    check("rst imem_addr", bus.imem_addr, 0);
    repeat (2) @(posedge clk);

    // Stream, then back-pressure until full, then drain.
    repeat (6) step(1'b1, 1'b0, 4'($urandom));
    step(1'b0, 1'b1, 4'd0);
    repeat (6) step(1'b0, 1'b0, 4'($urandom));
    repeat (8) step(1'b1, 1'b0, 4'($urandom));

    // Halt opcode at address 2.
    step(1'b0, 1'b1, 4'd0);
    imem[2] = 16'hF000;
    repeat (12) step(1'($urandom_range(0, 1)), 1'b0, 4'($urandom));
    repeat (6) step(1'b1, 1'b0, 4'($urandom));

    // End of memory from D.
    step(1'b1, 1'b1, 4'hD);
    imem[2] = 16'h3789;
    repeat (10) step(1'b1, 1'b0, 4'($urandom));

    // Flush while full.
    step(1'b0, 1'b1, 4'd0);
    repeat (5) step(1'b0, 1'b0, 4'($urandom));
    step(1'b1, 1'b1, 4'd8);
    repeat (6) step(1'b1, 1'b0, 4'($urandom));

    // Random interleaving with occasional redirects and fresh memory images.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        step(1'($urandom_range(0, 1)), 1'b1, 4'($urandom));
        fill_imem();
      end else begin
        step($urandom_range(0, 3) != 0, 1'b0, 4'($urandom));
      end
    end

    // Asynchronous reset with three entries queued.
    step(1'b0, 1'b1, 4'd0);
    fill_imem();
    repeat (3) step(1'b0, 1'b0, 4'($urandom));
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async iq_count", iq_count, 0);
    check("async deq_valid", bus.deq_valid, 0);
    check("async imem_addr", bus.imem_addr, 0);
    check("async iq_empty", iq_empty, 1);
    exp_q.delete(); mpc = '0; mhalt = 1'b0;
    repeat (8) step(1'b1, 1'b0, 4'($urandom));

    @(negedge clk);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
